// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified memory port arbiter: state encoding and
// default port widths.
package riscv_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int STRB_W     = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

endpackage : riscv_mem_pkg

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one memory port between instruction fetch and
// the memory stage; one access in flight, stale fetch responses are dropped.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                flush_f,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int SW = DATA_W / 8;

  arb_state_e      state_q;
  logic            drop_q;
  logic            we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     wstrb_q;

  logic fetch_done_s;
  logic data_done_s;

  // Arbitration FSM with the latched request attributes and the stale-fetch flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      wstrb_q <= {SW{1'b0}};
    end else begin
      case (state_q)
        ARB_IDLE: begin
          // Data is older in program order, so it always wins the port.
          if (dm_req) begin
            state_q <= ARB_DATA;
            we_q    <= dm_we;
            addr_q  <= dm_addr;
            wdata_q <= dm_wdata;
            wstrb_q <= dm_wstrb;
          end else if (if_req && !flush_f) begin
            state_q <= ARB_FETCH;
            drop_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= {DATA_W{1'b0}};
            wstrb_q <= {SW{1'b0}};
          end else begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_FETCH: begin
          if (mem_ready) begin
            state_q <= ARB_IDLE;
          end else if (flush_f) begin
            drop_q <= 1'b1;
          end else begin
            state_q <= ARB_FETCH;
          end
        end
        ARB_DATA: begin
          if (mem_ready) begin
            state_q <= ARB_IDLE;
          end else begin
            state_q <= ARB_DATA;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // Completion decode; a fetch completing under a redirect is never reported.
  always_comb begin
    data_done_s  = 1'b0;
    fetch_done_s = 1'b0;
    if (state_q == ARB_DATA) begin
      data_done_s = mem_ready;
    end else if (state_q == ARB_FETCH) begin
      fetch_done_s = mem_ready & ~drop_q & ~flush_f;
    end else begin
      data_done_s  = 1'b0;
      fetch_done_s = 1'b0;
    end
  end

  // Memory port attributes come only from the latched request.
  always_comb begin
    mem_req   = (state_q != ARB_IDLE);
    mem_we    = (state_q == ARB_DATA) & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wstrb = wstrb_q;
  end

  // Response return and stall requests toward the hazard unit.
  always_comb begin
    dm_valid  = data_done_s;
    if_valid  = fetch_done_s;
    dm_rdata  = data_done_s  ? mem_rdata : {DATA_W{1'b0}};
    if_rdata  = fetch_done_s ? mem_rdata : {DATA_W{1'b0}};
    stall_mem = dm_req & ~data_done_s;
    stall_if  = (if_req & ~fetch_done_s) | (dm_req & ~data_done_s);
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter: a per-cycle stimulus/expectation
// table plus a hand-written asynchronous reset sequence.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        flush_f;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = -1;

  typedef struct {
    logic        dmr;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dstrb;
    logic        ifr;
    logic [31:0] ifaddr;
    logic        fl;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic        e_ifv;
    logic [31:0] e_ifd;
    logic        e_dmv;
    logic [31:0] e_dmd;
    logic        e_sif;
    logic        e_smem;
  } vec_t;

  vec_t vq[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .flush_f(flush_f),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 0x%08h expected 0x%08h", nm, cur, act, exp);
    end
  endtask

  function automatic void add(
    input logic dmr, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
    input logic [3:0] dstrb, input logic ifr, input logic [31:0] ifaddr, input logic fl,
    input logic rdy, input logic [31:0] rdata,
    input logic e_req, input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata,
    input logic [3:0] e_strb, input logic e_ifv, input logic [31:0] e_ifd,
    input logic e_dmv, input logic [31:0] e_dmd, input logic e_sif, input logic e_smem);
    vec_t v;
    v.dmr = dmr; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata; v.dstrb = dstrb;
    v.ifr = ifr; v.ifaddr = ifaddr; v.fl = fl; v.rdy = rdy; v.rdata = rdata;
    v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_strb = e_strb;
    v.e_ifv = e_ifv; v.e_ifd = e_ifd; v.e_dmv = e_dmv; v.e_dmd = e_dmd;
    v.e_sif = e_sif; v.e_smem = e_smem;
    vq.push_back(v);
  endfunction

  task automatic idle_inputs();
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_wstrb = 4'h0;
    if_req = 1'b0; if_addr = 32'h0; flush_f = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  initial begin
    idle_inputs();
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    rst = 1'b0;
    #2;
    chk("rst_mem_req",   32'(mem_req),   32'h0);
    chk("rst_mem_we",    32'(mem_we),    32'h0);
    chk("rst_mem_addr",  mem_addr,       32'h0);
    chk("rst_mem_wdata", mem_wdata,      32'h0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("rst_if_valid",  32'(if_valid),  32'h0);
    chk("rst_dm_valid",  32'(dm_valid),  32'h0);
    idle_inputs();
    #10 rst = 1'b1;

    // A: single fetch, three busy cycles before the done pulse
    add(0,0,32'h0,32'h0,4'h0, 1,32'h100,0,0,32'h0,          0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h100,0,0,32'h0,          1,0,32'h100,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h100,0,0,32'h0,          1,0,32'h100,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h100,0,0,32'h0,          1,0,32'h100,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h100,0,1,32'h00500093,   1,0,32'h100,32'h0,4'h0, 1,32'h00500093,0,32'h0, 0,0);
    add(0,0,32'h0,32'h0,4'h0, 0,32'h0,0,0,32'h0,            0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 0,0);
    // B: load and fetch together; data first, fetch one cycle after dm_valid
    add(1,0,32'h2000,32'h0,4'h0, 1,32'h104,0,0,32'h0,       0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 1,1);
    add(1,0,32'h2000,32'h0,4'h0, 1,32'h104,0,0,32'h0,       1,0,32'h2000,32'h0,4'h0, 0,32'h0,0,32'h0, 1,1);
    add(1,0,32'h2000,32'h0,4'h0, 1,32'h104,0,1,32'h11223344, 1,0,32'h2000,32'h0,4'h0, 0,32'h0,1,32'h11223344, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h104,0,0,32'h0,          0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h104,0,1,32'h00A00113,   1,0,32'h104,32'h0,4'h0, 1,32'h00A00113,0,32'h0, 0,0);
    add(0,0,32'h0,32'h0,4'h0, 0,32'h0,0,0,32'h0,            0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 0,0);
    // C: store with inputs toggled mid-access, flush during data access
    add(1,1,32'h3000,32'hDEADBEEF,4'h3, 0,32'h0,0,0,32'h0,  0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 1,1);
    add(1,0,32'h4444,32'h12345678,4'hC, 1,32'h200,0,0,32'h0, 1,1,32'h3000,32'hDEADBEEF,4'h3, 0,32'h0,0,32'h0, 1,1);
    add(1,1,32'h5555,32'h0,4'hF, 1,32'h200,1,0,32'h0,       1,1,32'h3000,32'hDEADBEEF,4'h3, 0,32'h0,0,32'h0, 1,1);
    add(1,1,32'h3000,32'hDEADBEEF,4'h3, 0,32'h0,1,1,32'h0,  1,1,32'h3000,32'hDEADBEEF,4'h3, 0,32'h0,1,32'h0, 0,0);
    add(0,0,32'h0,32'h0,4'h0, 0,32'h0,0,0,32'h0,            0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 0,0);
    // D: flush in cycle 2 of a 4-cycle fetch; new PC issues after one idle cycle
    add(0,0,32'h0,32'h0,4'h0, 1,32'h200,0,0,32'h0,          0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h200,0,0,32'h0,          1,0,32'h200,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h300,1,0,32'h0,          1,0,32'h200,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h300,0,0,32'h0,          1,0,32'h200,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h300,0,1,32'hBAD0BAD0,   1,0,32'h200,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h300,0,0,32'h0,          0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h300,0,1,32'h00000013,   1,0,32'h300,32'h0,4'h0, 1,32'h00000013,0,32'h0, 0,0);
    add(0,0,32'h0,32'h0,4'h0, 0,32'h0,0,0,32'h0,            0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 0,0);
    // E: flush coincident with done; next fetch unaffected; done ignored in idle
    add(0,0,32'h0,32'h0,4'h0, 1,32'h400,0,0,32'h0,          0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h400,0,0,32'h0,          1,0,32'h400,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h500,1,1,32'hCAFEF00D,   1,0,32'h400,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h500,0,0,32'h0,          0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 1,32'h500,0,1,32'h00100073,   1,0,32'h500,32'h0,4'h0, 1,32'h00100073,0,32'h0, 0,0);
    add(0,0,32'h0,32'h0,4'h0, 0,32'h0,0,1,32'hFFFFFFFF,     0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 0,0);
    // F: fetch request suppressed by a same-cycle redirect in idle
    add(0,0,32'h0,32'h0,4'h0, 1,32'h600,1,0,32'h0,          0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 1,0);
    add(0,0,32'h0,32'h0,4'h0, 0,32'h0,0,0,32'h0,            0,0,32'h0,32'h0,4'h0, 0,32'h0,0,32'h0, 0,0);

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      dm_req = vq[i].dmr; dm_we = vq[i].dwe; dm_addr = vq[i].daddr;
      dm_wdata = vq[i].dwdata; dm_wstrb = vq[i].dstrb;
      if_req = vq[i].ifr; if_addr = vq[i].ifaddr; flush_f = vq[i].fl;
      mem_ready = vq[i].rdy; mem_rdata = vq[i].rdata;
      @(negedge clk);
      cur = i;
      chk("mem_req", 32'(mem_req), 32'(vq[i].e_req));
      if (vq[i].e_req) begin
        chk("mem_we",    32'(mem_we),    32'(vq[i].e_we));
        chk("mem_addr",  mem_addr,       vq[i].e_addr);
        chk("mem_wdata", mem_wdata,      vq[i].e_wdata);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(vq[i].e_strb));
      end
      chk("if_valid", 32'(if_valid), 32'(vq[i].e_ifv));
      if (vq[i].e_ifv) chk("if_rdata", if_rdata, vq[i].e_ifd);
      chk("dm_valid", 32'(dm_valid), 32'(vq[i].e_dmv));
      if (vq[i].e_dmv) chk("dm_rdata", dm_rdata, vq[i].e_dmd);
      chk("stall_if",  32'(stall_if),  32'(vq[i].e_sif));
      chk("stall_mem", 32'(stall_mem), 32'(vq[i].e_smem));
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a load, then a normal fetch
    cur = 1000;
    idle_inputs();
    dm_req = 1'b1; dm_addr = 32'h6000;
    @(posedge clk); #1;
    chk("rstseq_grant_req",  32'(mem_req), 32'h1);
    chk("rstseq_grant_addr", mem_addr,     32'h6000);
    mem_ready = 1'b1; mem_rdata = 32'h00000055;
    #1;
    chk("rstseq_dm_valid_pre", 32'(dm_valid), 32'h1);
    rst = 1'b0;
    #1;
    chk("rstseq_mem_req_async",  32'(mem_req),  32'h0);
    chk("rstseq_dm_valid_async", 32'(dm_valid), 32'h0);
    chk("rstseq_mem_addr_async", mem_addr,      32'h0);
    idle_inputs();
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstseq_idle_req", 32'(mem_req), 32'h0);
    if_req = 1'b1; if_addr = 32'h700;
    @(posedge clk); #1;
    chk("rstseq_fetch_req",  32'(mem_req), 32'h1);
    chk("rstseq_fetch_addr", mem_addr,     32'h700);
    chk("rstseq_fetch_we",   32'(mem_we),  32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h00000513;
    #1;
    chk("rstseq_if_valid", 32'(if_valid), 32'h1);
    chk("rstseq_if_rdata", if_rdata,      32'h00000513);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk("rstseq_done_req", 32'(mem_req), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores). Fixed priority, one access in flight, variable memory latency via a done pulse. Raises stall requests that the hazard unit ORs into its fetch/decode stall and flush logic. Drops fetch responses made stale by a branch/jalr redirect.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`

- `clk`  in  1  core clock, rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `if_req`  in  1  fetch wants an instruction at `if_addr`
- `if_addr`  in  ADDR_W  fetch address (PC)
- `if_rdata`  out  DATA_W  instruction, valid with `if_valid`
- `if_valid`  out  1  one-cycle fetch completion pulse
- `flush_f`  in  1  redirect this cycle (Eval_branch | jalr); in-flight/pending fetch is stale
- `dm_req`  in  1  memory stage wants an access
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_wstrb`  in  DATA_W/8  byte enables (stores only)
- `dm_rdata`  out  DATA_W  load data, valid with `dm_valid`
- `dm_valid`  out  1  one-cycle data completion pulse (loads and stores)
- `mem_req`  out  1  access active on memory port
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  access attributes
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ready`
- `mem_ready`  in  1  one-cycle done pulse for the current access
- `stall_if`  out  1  fetch must hold PC and decode register
- `stall_mem`  out  1  whole pipeline must hold (data access outstanding)

## Operation
- States: IDLE, FETCH, DATA.
- IDLE: data has priority. If `dm_req`, grant data: latch we/addr/wdata/wstrb, go DATA. Else if `if_req & ~flush_f`, grant fetch: latch addr, clear `drop`, go FETCH. Else stay.
- FETCH/DATA: `mem_req`=1; `mem_*` driven only from latched registers. Input changes have no effect.
- DATA + `mem_ready`: `dm_valid`=1, `dm_rdata`=`mem_rdata` (same cycle, combinational), go IDLE.
- FETCH + `mem_ready`: go IDLE; `if_valid`=1 and `if_rdata`=`mem_rdata` unless `drop` set or `flush_f` high this cycle, in which case `if_valid`=0.
- FETCH + `flush_f` without `mem_ready`: set `drop`; access runs to completion, response discarded.
- `flush_f` never affects a data access (older instruction).
- `stall_mem` = `dm_req & ~dm_valid`.
- `stall_if` = `if_req & ~if_valid`, or `stall_mem`.
- `mem_ready` outside FETCH/DATA ignored.
- No write data path on fetch: `mem_we`=0, `mem_wstrb`=0 in FETCH.

## Timing
- Reset (async, `rst`=0): state IDLE, `drop`=0, latched regs 0; `mem_req`, `mem_we`, `if_valid`, `dm_valid` = 0 immediately; `mem_addr`/`mem_wdata`/`mem_wstrb` = 0. Reset mid-access abandons it; memory must tolerate withdrawn `mem_req`.
- Grant at edge N (IDLE sample); `mem_req` high from N; earliest `mem_ready` in cycle N+1 → minimum 2-cycle access (1 grant + ≥1 busy).
- Completion cycle returns to IDLE; new grant no earlier than next cycle (one idle cycle between accesses, prevents re-issuing a request the pipeline has not yet retired).
- Simultaneous `dm_req` and `if_req` in IDLE: data granted, fetch waits; fetch wins the following IDLE if `dm_req` is low.
- Simultaneous `flush_f` and `mem_ready` in FETCH: response dropped.
- `stall_*` are combinational from inputs and state; no registered latency.

## Structure
- Shared package `riscv_mem_pkg`: state enum (`ARB_IDLE`, `ARB_FETCH`, `ARB_DATA`), `STRB_W` constant.
- Single flat module; no sub-module. One state register, one request-attribute register set, one `drop` flop.

## Test plan
- Single fetch, `if_addr`=0x100, memory returns 0x00500093 after 3 busy cycles → `mem_req` 4 cycles, `if_valid` 1 pulse with 0x00500093, `stall_if` high until that cycle.
- `dm_req` (load 0x2000) and `if_req` same cycle → DATA granted first, `mem_addr`=0x2000; fetch granted one cycle after `dm_valid`; `stall_mem` high throughout data access.
- Store `dm_wstrb`=0x3, `dm_wdata`=0xDEADBEEF, inputs toggled mid-access → `mem_wstrb`/`mem_wdata` stay 0x3/0xDEADBEEF until `mem_ready`; `dm_valid` pulses once.
- Fetch in flight, `flush_f` pulsed cycle 2 of 4 → access completes, `if_valid` stays 0; next fetch at new PC issues after one IDLE cycle.
- `flush_f` coincident with `mem_ready` in FETCH → `if_valid`=0; `flush_f` during DATA → `dm_valid` still asserted.
- `rst` low mid DATA access → `mem_req`/`dm_valid` drop to 0 asynchronously; after release, state IDLE and first request granted normally.
